// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU with single-cycle logic/add/sub/compare
// ops and iterative MUL (shift-add) / DIV (restoring) taking WIDTH cycles.
// Optional feature macro: ALU_DIV_EN. When defined, the iterative divider
// is built. When undefined, DIV completes in one cycle with result 0.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             valid_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Shared iterative working registers:
  //   MUL: acc = running high product, shf = multiplier / low product, opnd = multiplicand
  //   DIV: acc = partial remainder,    shf = dividend / quotient,      opnd = divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic             last_iter;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_shf;

  assign last_iter = (cnt_q == CW'(1));
  assign slt_bit   = ($signed(op_a) < $signed(op_b));

  // Single-cycle operation result; DIV lands here only when the divider is absent
  always_comb begin
    alu_res = op_a + op_b;
    case (sel)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOP:  alu_res = '0;
      OP_MUL:  alu_res = '0;
      OP_DIV:  alu_res = '0;
      default: alu_res = op_a + op_b;
    endcase
  end

  // One shift-add step: conditionally add multiplicand, then shift {carry,acc,shf} right
  always_comb begin
    mul_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_acc = mul_sum[WIDTH:1];
    mul_shf = {mul_sum[0], shf_q[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  // One restoring-divide step: shift next dividend bit into remainder, trial-subtract.
  // When the subtraction succeeds the difference is below the divisor, so W bits suffice.
  always_comb begin
    div_shift = {acc_q, shf_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo   = {shf_q[WIDTH-2:0], div_ge};
  end
`endif

  // FSM state and iteration counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start iterative ops from IDLE, count down and return on the last step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (sel == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = CW'(WIDTH);
          end
`ifdef ALU_DIV_EN
          else if (sel == OP_DIV) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH);
          end
`endif
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (last_iter) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: outputs change only on single-cycle accept or final iteration
  always_comb begin
    acc_d    = acc_q;
    shf_d    = shf_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (sel == OP_MUL) begin
            acc_d  = '0;
            shf_d  = op_b;
            opnd_d = op_a;
          end
`ifdef ALU_DIV_EN
          else if (sel == OP_DIV) begin
            acc_d  = '0;
            shf_d  = op_a;
            opnd_d = op_b;
          end
`endif
          else begin
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        shf_d = mul_shf;
        if (last_iter) begin
          result_d = mul_shf;
          hi_d     = mul_acc;
          zero_d   = (mul_shf == '0);
          valid_d  = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        acc_d = div_rem;
        shf_d = div_quo;
        if (last_iter) begin
          result_d = div_quo;
          hi_d     = div_rem;
          zero_d   = (div_quo == '0);
          valid_d  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath and output registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      shf_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      shf_q    <= shf_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative (WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_iterative;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1000;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [3:0]  sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        valid_out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_iterative #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sel       (sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .valid_out (valid_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    valid_in = 1'b1;
    sel      = s;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    sel      = OP_NOP;
    op_a     = '0;
    op_b     = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (result !== 32'h0 || hi !== 32'h0 || zero !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: result=%h hi=%h zero=%b vout=%b busy=%b, expected all 0",
               result, hi, zero, valid_out, busy);
    end
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_add_sub();
    drive(OP_ADD, 32'd5, 32'd7);
    @(negedge clk);
    tests++;
    if (result !== 32'd12 || zero !== 1'b0 || valid_out !== 1'b1 || busy !== 1'b0 || hi !== 32'h0) begin
      fails++;
      $display("FAIL add_5_7: result=%h hi=%h zero=%b vout=%b busy=%b, expected 0000000c 0 0 1 0",
               result, hi, zero, valid_out, busy);
    end
    $display("[TB] ADD 5+7 -> %0d", result);
    drive(OP_SUB, 32'd3, 32'd3);
    @(negedge clk);
    tests++;
    if (result !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL sub_3_3: result=%h zero=%b vout=%b busy=%b, expected 0 1 1 0",
               result, zero, valid_out, busy);
    end
    $display("[TB] SUB 3-3 -> %0d", result);
    idle();
    @(negedge clk);
    tests++;
    if (valid_out !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: result=%h zero=%b vout=%b, expected 0 1 0", result, zero, valid_out);
    end
    $display("[TB] idle cycle, outputs held");
  endtask

  task automatic test_logic_slt();
    logic [3:0]  vs [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] ve [7];
    vs[0] = OP_SLT;  va[0] = 32'hFFFFFFFF; vb[0] = 32'd1;        ve[0] = 32'd1;
    vs[1] = OP_SLT;  va[1] = 32'd1;        vb[1] = 32'hFFFFFFFF; ve[1] = 32'd0;
    vs[2] = 4'b1111; va[2] = 32'd2;        vb[2] = 32'd2;        ve[2] = 32'd4;
    vs[3] = OP_AND;  va[3] = 32'hF0F0_1234; vb[3] = 32'hFF00_00FF; ve[3] = 32'hF000_0034;
    vs[4] = OP_OR;   va[4] = 32'hF0F0_1234; vb[4] = 32'h0F00_0001; ve[4] = 32'hFFF0_1235;
    vs[5] = OP_ADD;  va[5] = 32'hFFFFFFFF; vb[5] = 32'd2;        ve[5] = 32'd1;
    vs[6] = OP_NOP;  va[6] = 32'd9;        vb[6] = 32'd9;        ve[6] = 32'd0;
    for (int i = 0; i < 7; i++) begin
      drive(vs[i], va[i], vb[i]);
      @(negedge clk);
      tests++;
      if (result !== ve[i] || valid_out !== 1'b1 || zero !== (ve[i] == 32'd0) || hi !== 32'h0) begin
        fails++;
        $display("FAIL single_%0d sel=%b: result=%h hi=%h zero=%b vout=%b, expected %h 0 %b 1",
                 i, vs[i], result, hi, zero, valid_out, ve[i], (ve[i] == 32'd0));
      end
      $display("[TB] sel=%b a=%h b=%h -> %h", vs[i], va[i], vb[i], result);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] ma [3];
    logic [31:0] mb [3];
    logic [31:0] er [3];
    logic [31:0] eh [3];
    logic [31:0] prev_r, prev_h;
    int busy_cycles, stray, early;
    bit done;
    ma[0] = 32'h0001_0000; mb[0] = 32'h0003_0000; er[0] = 32'h0;        eh[0] = 32'h3;
    ma[1] = 32'hFFFFFFFF;  mb[1] = 32'hFFFFFFFF;  er[1] = 32'h1;        eh[1] = 32'hFFFFFFFE;
    ma[2] = 32'h1234_5678; mb[2] = 32'h0000_0010; er[2] = 32'h2345_6780; eh[2] = 32'h1;
    for (int v = 0; v < 3; v++) begin
      prev_r = result;
      prev_h = hi;
      drive(OP_MUL, ma[v], mb[v]);
      busy_cycles = 0; stray = 0; early = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (busy) begin
          busy_cycles++;
          if (valid_out) stray++;
          if (result !== prev_r || hi !== prev_h) early++;
          drive(OP_ADD, 32'h11, 32'h22);
        end else begin
          done = 1;
        end
      end
      tests++;
      if (!done || busy_cycles != 32) begin
        fails++;
        $display("FAIL mul_%0d_busy: busy cycles=%0d done=%0d, expected 32 cycles", v, busy_cycles, done);
      end
      tests++;
      if (valid_out !== 1'b1 || result !== er[v] || hi !== eh[v] || zero !== (er[v] == 32'd0)) begin
        fails++;
        $display("FAIL mul_%0d_result: result=%h hi=%h zero=%b vout=%b, expected %h %h %b 1",
                 v, result, hi, zero, valid_out, er[v], eh[v], (er[v] == 32'd0));
      end
      tests++;
      if (stray != 0 || early != 0) begin
        fails++;
        $display("FAIL mul_%0d_during_busy: stray vout=%0d early output changes=%0d, expected 0 0", v, stray, early);
      end
      $display("[TB] MUL %h*%h -> hi=%h lo=%h after %0d busy cycles", ma[v], mb[v], hi, result, busy_cycles);
      if (v == 2) begin
        drive(OP_ADD, 32'd4, 32'd5);
        @(negedge clk);
        tests++;
        if (result !== 32'd9 || valid_out !== 1'b1 || busy !== 1'b0 || hi !== 32'h0) begin
          fails++;
          $display("FAIL back_to_back_add: result=%h hi=%h vout=%b busy=%b, expected 9 0 1 0",
                   result, hi, valid_out, busy);
        end
        $display("[TB] back-to-back ADD 4+5 -> %0d", result);
      end
      idle();
      @(negedge clk);
    end
  endtask

  task automatic test_div();
`ifdef ALU_DIV_EN
    logic [31:0] da [3];
    logic [31:0] db [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    int busy_cycles;
    bit done;
    da[0] = 32'd100;      db[0] = 32'd7;  eq[0] = 32'd14;        er[0] = 32'd2;
    da[1] = 32'd9;        db[1] = 32'd0;  eq[1] = 32'hFFFFFFFF;  er[1] = 32'd9;
    da[2] = 32'hFFFFFFFF; db[2] = 32'h10; eq[2] = 32'h0FFFFFFF;  er[2] = 32'hF;
    for (int v = 0; v < 3; v++) begin
      drive(OP_DIV, da[v], db[v]);
      busy_cycles = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (busy) begin
          busy_cycles++;
          idle();
        end else begin
          done = 1;
        end
      end
      tests++;
      if (!done || busy_cycles != 32 || valid_out !== 1'b1 || result !== eq[v] || hi !== er[v]) begin
        fails++;
        $display("FAIL div_%0d: busy=%0d result=%h hi=%h vout=%b, expected 32 %h %h 1",
                 v, busy_cycles, result, hi, valid_out, eq[v], er[v]);
      end
      $display("[TB] DIV %h/%h -> q=%h r=%h", da[v], db[v], result, hi);
      idle();
      @(negedge clk);
    end
`else
    drive(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    tests++;
    if (result !== 32'd0 || hi !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL div_disabled: result=%h hi=%h zero=%b vout=%b busy=%b, expected 0 0 1 1 0",
               result, hi, zero, valid_out, busy);
    end
    idle();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL div_disabled_after: busy=%b vout=%b, expected 0 0", busy, valid_out);
    end
    $display("[TB] DIV 100/7 without divider -> %0d", result);
`endif
  endtask

  task automatic test_reset_mid_mul();
    drive(OP_ADD, 32'd1, 32'd2);
    @(negedge clk);
    drive(OP_MUL, 32'h0001_0000, 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle();
    end
    tests++;
    if (busy !== 1'b1 || result !== 32'd3) begin
      fails++;
      $display("FAIL mid_mul_state: busy=%b result=%h, expected 1 00000003", busy, result);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (result !== 32'h0 || hi !== 32'h0 || zero !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_mul: result=%h hi=%h zero=%b vout=%b busy=%b, expected all 0",
               result, hi, zero, valid_out, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    tests++;
    if (result !== 32'd2 || valid_out !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL add_after_reset: result=%h vout=%b busy=%b, expected 2 1 0", result, valid_out, busy);
    end
    $display("[TB] reset during MUL, then ADD 1+1 -> %0d", result);
    idle();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_out === 1'b1 && c > 0) begin
        tests++;
        fails++;
        $display("FAIL stray_vout_after_reset: valid_out=1 at cycle %0d, expected 0", c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_slt();
    test_mul();
    test_div();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
